sc_dmem_loader: RTL
===================

Name: sc_dmem_loader

Overview:
Bus initiator on the data-memory side of the single-cycle CPU. It receives a byte stream over a valid/ready handshake and packs each group of 4 bytes into a 32-bit word, first byte in bits 31:24. It writes each word into data memory through the addr/datain/we port, and holds the CPU while it owns that port. It is used to preload data memory before program run or between runs.

Parameters:
BASE_ADDR, 32'h0000_0000, byte address of the first word written; bits 1:0 must be 0.
MAX_WORDS, 32, depth of the target memory in words; matches 5-bit word index addr[6:2].

Ports:
clock  input  1  system clock; all state changes on the rising edge.
resetn  input  1  asynchronous, active-low reset.
start  input  1  one-cycle request to begin a load; ignored while busy.
word_len  input  6  number of words to load, sampled when start is accepted; valid range 1..MAX_WORDS.
abort  input  1  synchronous cancel; takes priority over all other inputs except reset.
byte_in  input  8  stream data.
byte_valid  input  1  byte_in holds valid data.
byte_ready  output  1  loader accepts byte_in this cycle.
mem_addr  output  32  data-memory byte address; always word-aligned.
mem_datain  output  32  data-memory write data.
mem_we  output  1  data-memory write enable.
cpu_hold  output  1  CPU must stall and release the data-memory port.
busy  output  1  a load is in progress.
done  output  1  one-cycle pulse when the last word has been written.
words_written  output  6  count of words committed in the current or most recent load.

Behaviour:
- Reset, asynchronous on resetn=0: state IDLE. All outputs are 0: byte_ready, mem_addr, mem_datain, mem_we, cpu_hold, busy, done, words_written. Internal byte count and word index are 0. Reset in the middle of a load discards the partial word and performs no write.
- States are IDLE, COLLECT, WRITE and FINISH.
- IDLE:
  - start=1 with word_len in 1..MAX_WORDS: latch len, clear words_written and the word index, go to COLLECT.
  - start with word_len=0 or word_len>MAX_WORDS: ignored, stay in IDLE.
- COLLECT:
  - byte_ready=1; busy=1; cpu_hold=1.
  - A byte transfers on a rising edge with byte_valid & byte_ready.
  - Byte k of the word (k=0..3) goes to bits [31-8k:24-8k] of the assembly register.
  - When the 4th byte transfers, go to WRITE. byte_ready drops to 0 in the following cycle.
  - byte_valid=0 stalls indefinitely; there is no timeout.
- WRITE, exactly one cycle:
  - mem_we=1, mem_addr = BASE_ADDR + 4*index, mem_datain = assembled word.
  - These three outputs are registered and stable for the whole cycle. Memory commits during the low phase of clock.
  - byte_ready=0.
  - On exit, index and words_written increment by 1.
  - If the new words_written equals len, go to FINISH; otherwise go to COLLECT with the byte count at 0.
- FINISH, one cycle: done=1, busy=1, cpu_hold=1, mem_we=0; then IDLE.
- Outside WRITE: mem_we=0. mem_addr and mem_datain hold their last written values; they are don't-care to memory.
- IDLE: cpu_hold=0 and busy=0. words_written holds its final value until the next accepted start.
- Write throughput: one word per 5 cycles minimum (4 byte-transfer cycles plus 1 write cycle).
- start while busy is ignored and does not restart the load.
- Any byte transfer during the last word only completes that word; no extra bytes are consumed after len words.
- abort=1 in COLLECT, WRITE or FINISH:
  - Next state is IDLE and the partial word is discarded.
  - If abort coincides with WRITE, that cycle's mem_we is still 1 (already registered) and the word counts as written; done is not pulsed.
  - abort in IDLE has no effect; abort+start in the same IDLE cycle leaves the block in IDLE.
- Addresses never wrap, because len ≤ MAX_WORDS bounds the index at MAX_WORDS-1.

Test Plan:
- Reset mid-load: assert resetn=0 during COLLECT after 2 bytes -> all outputs 0 immediately; no mem_we pulse; the next load starts at byte 0.
- Single word: start with word_len=1, bytes 8'h12, 8'h34, 8'h56, 8'h78 on consecutive cycles -> one cycle with mem_we=1, mem_addr=32'h0, mem_datain=32'h12345678; done pulses the following cycle; words_written=1; cpu_hold falls after done.
- Full depth with gaps: word_len=32, byte_valid randomly deasserted -> 32 writes to addresses 0x00..0x7C in order with the correct data; no byte is lost or duplicated; words_written=32.
- Illegal length and busy start: word_len=0 -> stays IDLE, busy=0. start pulsed during an active word_len=3 load -> still exactly 3 writes.
- Abort: word_len=4, abort after 6 bytes -> exactly 1 write (addr 0x0), no done, IDLE next cycle, byte_ready=0.
- Abort on a WRITE cycle: abort asserted while mem_we=1 for word 2 -> that write occurs at addr 0x4, words_written=2, no done.

Source files
------------

// File: rtl/sc_dmem_loader.sv
`default_nettype none
// ============================================================================
// Module      : sc_dmem_loader
// Description : Packs a valid/ready byte stream into 32-bit words (first byte
//               in bits 31:24) and writes them into data memory, holding the
//               CPU off the data-memory port while a load is running.
// Revision    : 1.0 - initial release
// ============================================================================
module sc_dmem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 32
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        start,
    input  logic [5:0]  word_len,
    input  logic        abort,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_datain,
    output logic        mem_we,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic [5:0]  words_written
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_WRITE   = 2'd2,
        S_FINISH  = 2'd3
    } state_t;

    localparam logic [6:0] c_max_words = 7'(MAX_WORDS);

    state_t      r_state;
    state_t      w_next;
    logic [5:0]  r_len;
    logic [1:0]  r_byte_cnt;
    logic [23:0] r_asm;
    // Word index and committed-word count always advance together, so one
    // register serves as both.
    logic [5:0]  r_words;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_datain;
    logic        r_mem_we;

    logic        w_len_ok;
    logic        w_xfer;
    logic        w_last_byte;
    logic [5:0]  w_words_inc;

    assign w_len_ok    = (word_len != 6'd0) && ({1'b0, word_len} <= c_max_words);
    assign w_xfer      = byte_valid && (r_state == S_COLLECT);
    assign w_last_byte = w_xfer && (r_byte_cnt == 2'd3);
    assign w_words_inc = r_words + 6'd1;

    assign mem_addr      = r_mem_addr;
    assign mem_datain    = r_mem_datain;
    assign mem_we        = r_mem_we;
    assign words_written = r_words;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        byte_ready = 1'b0;
        busy       = 1'b0;
        cpu_hold   = 1'b0;
        done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && !abort && w_len_ok) begin
                    w_next = S_COLLECT;
                end
            end
            S_COLLECT: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                cpu_hold   = 1'b1;
                if (abort) begin
                    w_next = S_IDLE;
                end else if (w_last_byte) begin
                    w_next = S_WRITE;
                end
            end
            S_WRITE: begin
                busy     = 1'b1;
                cpu_hold = 1'b1;
                if (abort) begin
                    w_next = S_IDLE;
                end else if (w_words_inc == r_len) begin
                    w_next = S_FINISH;
                end else begin
                    w_next = S_COLLECT;
                end
            end
            S_FINISH: begin
                busy     = 1'b1;
                cpu_hold = 1'b1;
                done     = 1'b1;
                w_next   = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Write strobe, address and data are all flops so memory sees clean,
    // stable values for the entire WRITE cycle.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_len        <= 6'd0;
            r_byte_cnt   <= 2'd0;
            r_asm        <= 24'd0;
            r_words      <= 6'd0;
            r_mem_addr   <= 32'd0;
            r_mem_datain <= 32'd0;
            r_mem_we     <= 1'b0;
        end else begin
            r_mem_we <= (w_next == S_WRITE);
            case (r_state)
                S_IDLE: begin
                    if (w_next == S_COLLECT) begin
                        r_len      <= word_len;
                        r_words    <= 6'd0;
                        r_byte_cnt <= 2'd0;
                    end
                end
                S_COLLECT: begin
                    if (abort) begin
                        r_byte_cnt <= 2'd0;
                    end else if (w_xfer) begin
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        r_asm      <= {r_asm[15:0], byte_in};
                        if (w_last_byte) begin
                            r_mem_addr   <= BASE_ADDR + {24'd0, r_words, 2'b00};
                            r_mem_datain <= {r_asm, byte_in};
                        end
                    end
                end
                S_WRITE: begin
                    // The word is committed even when abort lands on this cycle.
                    r_words <= w_words_inc;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire
